// File: rtl/dma_dispatcher.sv
// Descriptor dispatcher for the DMA engine: buffers host descriptors in a FIFO,
// issues them one at a time to the copy engine and reports status/counters.
module dma_dispatcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int DESC_W     = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              desc_valid,
  input  logic [DESC_W-1:0] desc_data,
  output logic              desc_ready,
  input  logic              ctl_stop,
  input  logic              ctl_reset,
  input  logic              ctl_stop_on_error,
  input  logic              irq_clr,
  output logic              eng_valid,
  output logic [95:0]       eng_data,
  input  logic              eng_ready,
  input  logic              eng_done,
  input  logic              eng_error,
  output logic [31:0]       status,
  output logic [15:0]       fill_level,
  output logic [31:0]       seq_num
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT      = 2'd2,
    ST_RESETTING = 2'd3
  } state_t;

  state_t state_r, state_nxt;

  // Only {src,dest,length} and the completion-irq control bit are kept per entry.
  logic [96:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_r, rd_ptr_nxt;
  logic [CW-1:0] count_r, count_nxt;

  logic          desc_ready_r, desc_ready_nxt;
  logic          eng_valid_r, eng_valid_nxt;
  logic [95:0]   eng_data_r, eng_data_nxt;
  logic          irq_en_r, irq_en_nxt;
  logic [15:0]   issued_r, issued_nxt;
  logic [15:0]   completed_r, completed_nxt;
  logic          soe_r, soe_nxt;
  logic          irq_r, irq_nxt;
  logic [31:0]   status_r, status_nxt;
  logic [15:0]   fill_level_r;
  logic [31:0]   seq_num_r;

  logic          push_s;
  logic          pop_s;
  logic [96:0]   head_s;
  logic [31:0]   head_len_s;
  logic          unused_desc_s;

  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign head_len_s    = head_s[32:1];
  assign unused_desc_s = ^{desc_data[31:15], desc_data[13:0]};

  // Next-state, FIFO bookkeeping, counters and status; ctl_reset overrides everything.
  always_comb begin
    state_nxt     = state_r;
    wr_ptr_nxt    = wr_ptr_r;
    rd_ptr_nxt    = rd_ptr_r;
    count_nxt     = count_r;
    eng_valid_nxt = eng_valid_r;
    eng_data_nxt  = eng_data_r;
    irq_en_nxt    = irq_en_r;
    issued_nxt    = issued_r;
    completed_nxt = completed_r;
    soe_nxt       = soe_r;
    irq_nxt       = irq_r;
    push_s        = 1'b0;
    pop_s         = 1'b0;

    if (ctl_reset) begin
      state_nxt     = ST_RESETTING;
      wr_ptr_nxt    = {AW{1'b0}};
      rd_ptr_nxt    = {AW{1'b0}};
      count_nxt     = {CW{1'b0}};
      eng_valid_nxt = 1'b0;
      soe_nxt       = 1'b0;
      irq_nxt       = 1'b0;
    end else begin
      push_s = desc_valid && desc_ready_r;
      if (irq_clr) begin
        irq_nxt = 1'b0;
      end else begin
        irq_nxt = irq_r;
      end

      case (state_r)
        ST_IDLE: begin
          if ((count_r != {CW{1'b0}}) && !ctl_stop && !soe_r) begin
            pop_s = 1'b1;
            if (head_len_s == 32'h0000_0000) begin
              // Zero-length descriptors retire without touching the engine.
              issued_nxt    = issued_r + 16'd1;
              completed_nxt = completed_r + 16'd1;
            end else begin
              eng_data_nxt  = head_s[96:1];
              irq_en_nxt    = head_s[0];
              eng_valid_nxt = 1'b1;
              state_nxt     = ST_ISSUE;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (eng_ready) begin
            issued_nxt    = issued_r + 16'd1;
            eng_valid_nxt = 1'b0;
            state_nxt     = ST_WAIT;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            completed_nxt = completed_r + 16'd1;
            soe_nxt       = soe_r || (eng_error && ctl_stop_on_error);
            state_nxt     = ST_IDLE;
            if (irq_en_r) begin
              irq_nxt = 1'b1;
            end else begin
              irq_nxt = irq_nxt;
            end
          end else begin
            state_nxt = ST_WAIT;
          end
        end
        ST_RESETTING: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase

      if (push_s) begin
        wr_ptr_nxt = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt = count_r + CNT_ONE;
        2'b01:   count_nxt = count_r - CNT_ONE;
        default: count_nxt = count_r;
      endcase
    end

    desc_ready_nxt = (count_nxt != FULL_CNT);

    status_nxt     = 32'h0000_0000;
    status_nxt[0]  = (state_nxt != ST_IDLE) || (count_nxt != {CW{1'b0}});
    status_nxt[1]  = (count_nxt == {CW{1'b0}});
    status_nxt[2]  = (count_nxt == FULL_CNT);
    status_nxt[3]  = 1'b1;
    status_nxt[5]  = (ctl_stop && (state_nxt == ST_IDLE)) || soe_nxt;
    status_nxt[6]  = (state_nxt == ST_RESETTING);
    status_nxt[7]  = soe_nxt;
    status_nxt[9]  = irq_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath, counters and registered CSR-facing outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      desc_ready_r <= 1'b1;
      eng_valid_r  <= 1'b0;
      eng_data_r   <= 96'h0;
      irq_en_r     <= 1'b0;
      issued_r     <= 16'h0000;
      completed_r  <= 16'h0000;
      soe_r        <= 1'b0;
      irq_r        <= 1'b0;
      status_r     <= 32'h0000_000A;
      fill_level_r <= 16'h0000;
      seq_num_r    <= 32'h0000_0000;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt;
      rd_ptr_r     <= rd_ptr_nxt;
      count_r      <= count_nxt;
      desc_ready_r <= desc_ready_nxt;
      eng_valid_r  <= eng_valid_nxt;
      eng_data_r   <= eng_data_nxt;
      irq_en_r     <= irq_en_nxt;
      issued_r     <= issued_nxt;
      completed_r  <= completed_nxt;
      soe_r        <= soe_nxt;
      irq_r        <= irq_nxt;
      status_r     <= status_nxt;
      fill_level_r <= {{(16-CW){1'b0}}, count_nxt};
      seq_num_r    <= {completed_nxt, issued_nxt};
    end
  end

  // Descriptor storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {desc_data[127:32], desc_data[14]};
    end
  end

  assign desc_ready = desc_ready_r;
  assign eng_valid  = eng_valid_r;
  assign eng_data   = eng_data_r;
  assign status     = status_r;
  assign fill_level = fill_level_r;
  assign seq_num    = seq_num_r;

endmodule

// File: tb/tb_dma_dispatcher.sv
// Self-checking bench for dma_dispatcher: directed scenarios plus randomized
// descriptor traffic checked against a queue-based transaction model.
module tb_dma_dispatcher;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         desc_valid;
  logic [127:0] desc_data;
  logic         desc_ready;
  logic         ctl_stop;
  logic         ctl_reset;
  logic         ctl_stop_on_error;
  logic         irq_clr;
  logic         eng_valid;
  logic [95:0]  eng_data;
  logic         eng_ready;
  logic         eng_done;
  logic         eng_error;
  logic [31:0]  status;
  logic [15:0]  fill_level;
  logic [31:0]  seq_num;

  logic [127:0] model_q [$];
  logic [15:0]  exp_issued;
  logic [15:0]  exp_completed;
  logic         exp_irq;
  int           checks = 0;
  int           errors = 0;

  dma_dispatcher #(.FIFO_DEPTH(16), .DESC_W(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_data(desc_data), .desc_ready(desc_ready),
    .ctl_stop(ctl_stop), .ctl_reset(ctl_reset), .ctl_stop_on_error(ctl_stop_on_error),
    .irq_clr(irq_clr),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_error(eng_error),
    .status(status), .fill_level(fill_level), .seq_num(seq_num)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; desc_valid = 1'b0; desc_data = 128'h0; ctl_stop = 1'b0;
    ctl_reset = 1'b0; ctl_stop_on_error = 1'b0; irq_clr = 1'b0;
    eng_ready = 1'b0; eng_done = 1'b0; eng_error = 1'b0;
    model_q.delete();
    exp_issued = 16'h0; exp_completed = 16'h0; exp_irq = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [127:0] d);
    desc_valid = 1'b1;
    desc_data  = d;
    if (desc_ready === 1'b1) model_q.push_back(d);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic chk_seq(input string tag);
    chk(tag, seq_num, {exp_completed, exp_issued});
  endtask

  // Act as the copy engine for n non-zero-length commands, checking order and data.
  task automatic serve(input int n, input bit err, input bit clr_with_done);
    logic [127:0] d;
    int t;
    for (int k = 0; k < n; k++) begin
      while (model_q.size() > 0 && model_q[0][63:32] == 32'h0) begin
        d = model_q.pop_front();
        exp_issued++;
        exp_completed++;
      end
      t = 0;
      while (eng_valid !== 1'b1 && t < 100) begin
        tick();
        t++;
      end
      chk("eng_valid_wait", eng_valid, 1'b1);
      if (model_q.size() == 0) begin
        chk("model_nonempty", 1'b0, 1'b1);
        return;
      end
      d = model_q.pop_front();
      chk("eng_data", eng_data, d[127:32]);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("eng_data_hold", {eng_valid, eng_data}, {1'b1, d[127:32]});
      end
      eng_ready = 1'b1;
      tick();
      eng_ready = 1'b0;
      exp_issued++;
      chk("eng_valid_drop", eng_valid, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      eng_done = 1'b1; eng_error = err; irq_clr = clr_with_done;
      tick();
      eng_done = 1'b0; eng_error = 1'b0; irq_clr = 1'b0;
      exp_completed++;
      if (d[14]) exp_irq = 1'b1;
      else if (clr_with_done) exp_irq = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] d;
    int t;
    int nz;

    // Reset values
    reset_n = 1'b0; desc_valid = 1'b0; desc_data = 128'h0; ctl_stop = 1'b0;
    ctl_reset = 1'b0; ctl_stop_on_error = 1'b0; irq_clr = 1'b0;
    eng_ready = 1'b0; eng_done = 1'b0; eng_error = 1'b0;
    repeat (2) tick();
    chk("rst_status", status, 32'h0000_000A);
    chk("rst_ready", desc_ready, 1'b1);
    chk("rst_eng_valid", eng_valid, 1'b0);
    chk("rst_fill", fill_level, 16'h0);
    chk("rst_seq", seq_num, 32'h0);
    do_reset();

    // Single descriptor, latency and irq
    push({32'h0000_1000, 32'h0000_2000, 32'h0000_0040, 32'h8000_4000});
    chk("t1_valid_n1", eng_valid, 1'b0);
    chk("t1_fill1", fill_level, 16'd1);
    tick();
    chk("t1_valid_n2", eng_valid, 1'b1);
    chk("t1_data", eng_data, {32'h0000_1000, 32'h0000_2000, 32'h0000_0040});
    chk("t1_status_busy", status, 32'h0000_000B);
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    chk("t1_seq_issued", seq_num, 32'h0000_0001);
    repeat (4) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t1_seq_done", seq_num, 32'h0001_0001);
    chk("t1_irq", status, 32'h0000_020A);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("t1_irq_clr", status, 32'h0000_000A);

    // Fill to full with the engine stalled, then drain
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = {32'h0000_3000 + 32'(i * 64), 32'h0000_8000 + 32'(i * 64), 32'h0000_0010, 32'h0};
      push(d);
    end
    chk("t2_fill15", fill_level, 16'd15);
    chk("t2_ready15", desc_ready, 1'b1);
    push({32'h0000_5000, 32'h0000_6000, 32'h0000_0020, 32'h0});
    chk("t2_fill16", fill_level, 16'd16);
    chk("t2_ready_full", desc_ready, 1'b0);
    chk("t2_status_full", status, 32'h0000_000D);
    push({32'hDEAD_0000, 32'hBEEF_0000, 32'h0000_0030, 32'h0});
    chk("t2_full_drop", fill_level, 16'd16);
    serve(17, 1'b0, 1'b0);
    tick();
    chk_seq("t2_seq");
    chk("t2_seq_lit", seq_num, 32'h0011_0011);
    chk("t2_empty", fill_level, 16'd0);

    // ctl_stop holds queued descriptors
    ctl_stop = 1'b1;
    for (int i = 0; i < 3; i++) push({32'h0000_7000 + 32'(i), 32'h0000_9000, 32'h0000_0100, 32'h0});
    repeat (3) tick();
    chk("t3_no_issue", eng_valid, 1'b0);
    chk("t3_status_stopped", status, 32'h0000_0029);
    chk("t3_fill", fill_level, 16'd3);
    ctl_stop = 1'b0;
    serve(3, 1'b0, 1'b0);
    tick();
    chk_seq("t3_seq");

    // Stop on error, then recover with ctl_reset
    ctl_stop_on_error = 1'b1;
    push({32'h0000_A000, 32'h0000_B000, 32'h0000_0080, 32'h0});
    push({32'h0000_A100, 32'h0000_B100, 32'h0000_0080, 32'h0});
    serve(1, 1'b1, 1'b0);
    chk("t4_soe_status", status, 32'h0000_00A9);
    repeat (4) tick();
    chk("t4_no_issue", eng_valid, 1'b0);
    chk("t4_fill", fill_level, 16'd1);
    ctl_reset = 1'b1;
    tick();
    ctl_reset = 1'b0;
    model_q.delete();
    chk("t4_resetting", status, 32'h0000_004B);
    chk("t4_flush", fill_level, 16'd0);
    tick();
    chk("t4_after_reset", status, 32'h0000_000A);
    chk_seq("t4_seq");
    ctl_stop_on_error = 1'b0;

    // ctl_reset during WAIT with coincident push and eng_done
    push({32'h0000_C000, 32'h0000_D000, 32'h0000_0040, 32'h0});
    t = 0;
    while (eng_valid !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk("t5_issue", eng_valid, 1'b1);
    d = model_q.pop_front();
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    exp_issued++;
    repeat (2) tick();
    ctl_reset = 1'b1; desc_valid = 1'b1; eng_done = 1'b1;
    desc_data = {32'h0000_E000, 32'h0000_F000, 32'h0000_0040, 32'h0};
    tick();
    ctl_reset = 1'b0; desc_valid = 1'b0; eng_done = 1'b0;
    chk("t5_resetting", status, 32'h0000_004B);
    chk("t5_push_dropped", fill_level, 16'd0);
    tick();
    chk("t5_one_cycle", status, 32'h0000_000A);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    repeat (3) tick();
    chk("t5_no_issue", eng_valid, 1'b0);
    chk_seq("t5_seq");

    // Zero-length descriptor between two normal ones; irq set beats irq_clr
    push({32'h0001_0000, 32'h0002_0000, 32'h0000_0100, 32'h0});
    push({32'h0003_0000, 32'h0004_0000, 32'h0000_0000, 32'h0});
    push({32'h0005_0000, 32'h0006_0000, 32'h0000_0008, 32'h0000_4000});
    serve(1, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b1);
    tick();
    chk_seq("t6_seq");
    chk("t6_irq_wins", status, 32'h0000_020A);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    exp_irq = 1'b0;
    chk("t6_irq_clr", status[9], exp_irq);

    // Randomized traffic against the queue model
    for (int r = 0; r < 10; r++) begin
      int k;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        logic [31:0] len;
        logic [31:0] ctrl;
        len  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        ctrl = $urandom & 32'hFFFF_BFFF;
        if (len != 32'h0 && $urandom_range(0, 1) == 1) ctrl = ctrl | 32'h0000_4000;
        push({$urandom, $urandom, len, ctrl});
      end
      nz = 0;
      for (int i = 0; i < model_q.size(); i++) if (model_q[i][63:32] != 32'h0) nz++;
      serve(nz, 1'b0, 1'b0);
      repeat (8) tick();
      while (model_q.size() > 0) begin
        d = model_q.pop_front();
        exp_issued++;
        exp_completed++;
      end
      chk_seq("rnd_seq");
      chk("rnd_fill", fill_level, 16'd0);
      chk("rnd_irq", status[9], exp_irq);
      if (exp_irq) begin
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        exp_irq = 1'b0;
        chk("rnd_irq_clr", status[9], exp_irq);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_dispatcher.md
Name: dma_dispatcher

Overview:
- Sequences the DMA engine. Buffers host-written descriptors in a FIFO and issues them one at a time to the read/write engine.
- Tracks completion, errors and stop/reset control, and produces the status, fill-level and sequence-number fields read back through the DMA CSR block.
- Sits between the CSR decoder (descriptor and control writes) and the copy engine.

Parameters:
- FIFO_DEPTH, 16, descriptor FIFO entries; power of two, 8..1024.
- DESC_W, 128, width of a packed descriptor {src_addr[127:96], dest_addr[95:64], length[63:32], control[31:0]}.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor push; pulsed when the control word is written with go=1.
- desc_data  in  DESC_W  descriptor.
- desc_ready  out  1  FIFO not full.
- ctl_stop  in  1  level; stop_dispatcher.
- ctl_reset  in  1  one-cycle pulse; reset_dispatcher.
- ctl_stop_on_error  in  1  level.
- irq_clr  in  1  one-cycle pulse; clears irq.
- eng_valid  out  1  command valid to engine.
- eng_data  out  96  {src,dest,length}.
- eng_ready  in  1  engine accepts.
- eng_done  in  1  one-cycle completion pulse.
- eng_error  in  1  qualifies eng_done.
- status  out  32  t_dma_csr_status layout.
- fill_level  out  16  FIFO occupancy, zero-extended.
- seq_num  out  32  {completed[15:0], issued[15:0]}.

Behaviour:
- Reset (reset_n low, async): FIFO empty; state IDLE; all counters 0; irq=0; eng_valid=0; desc_ready=1; status = 0x0000000A (descriptor_buffer_empty=1, response_buffer_empty=1).
- FIFO: count width log2(FIFO_DEPTH)+1.
  - Push when desc_valid && desc_ready.
  - Pop when the FSM leaves IDLE with a descriptor.
  - A simultaneous push and pop leaves the count unchanged; a push when full cannot happen (desc_ready=0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty && !ctl_stop && !stopped_on_error, pop the head.
    - If length==0, the descriptor completes immediately (completed++, issued++), with no engine command and state stays IDLE.
    - Otherwise load eng_data, go to ISSUE next cycle.
  - ISSUE: eng_valid=1 and eng_data held stable until eng_ready. On accept, issued++ and go to WAIT.
  - WAIT: on eng_done, completed++.
    - If eng_error && ctl_stop_on_error: set stopped_on_error, go to IDLE (latched stall).
    - Otherwise go to IDLE.
    - If the descriptor's control bit 14 (transfer_complete_irq) was set, irq=1 on the same edge.
  - RESETTING: one cycle, entered on ctl_reset from any state. Flushes the FIFO, clears stopped_on_error and irq, drops eng_valid, then returns to IDLE. Counters are not cleared.
- ctl_stop asserted mid-transfer: the in-flight command finishes (ISSUE/WAIT continue); no new pop occurs.
- ctl_reset takes priority over every other event in the same cycle, including push and eng_done. A push in that cycle is dropped.
- eng_done outside WAIT is ignored.
- irq_clr clears irq; if irq_clr and a new irq set coincide, the set wins.
- Status bits:
  - busy = (state != IDLE) || FIFO non-empty.
  - descriptor_buffer_empty and descriptor_buffer_full follow the count.
  - response_buffer_empty=1, response_buffer_full=0.
  - resetting = (state == RESETTING).
  - stopped = ctl_stop && state == IDLE, or stopped_on_error.
  - stopped_on_error, and irq (bit 9).
  - stopped_on_early_termination=0; bits 31:10 = 0.
- All outputs are registered; status, fill_level and seq_num update the cycle after the causing event.
- 16-bit counters wrap 0xFFFF→0x0000.
- Latency: push in an empty IDLE FIFO at cycle N gives eng_valid=1 at N+2.

Test Plan:
- Reset, push one descriptor (len=0x40, src=0x1000, dest=0x2000, ctrl=0x80004000), then eng_ready=1 and eng_done 5 cycles later → eng_valid at N+2 with eng_data={0x1000,0x2000,0x40}; seq_num=0x00010001; irq=1; irq_clr→status.irq=0.
- Push 16 descriptors with the engine stalled (eng_ready=0) → fill_level=15 (one popped to ISSUE), then push one more → fill_level=16, desc_ready=0, descriptor_buffer_full=1; drain all → seq_num=0x00110011 after 17 completions.
- ctl_stop=1 with 3 queued → no eng_valid, status.stopped=1, busy=1; release → all 3 issue in order.
- ctl_stop_on_error=1, eng_done+eng_error on descriptor 1 of 2 → stopped_on_error=1, second not issued; ctl_reset → FIFO flushed, fill_level=0, status=0x0000000A.
- ctl_reset during WAIT, coincident with desc_valid → resetting=1 for one cycle, pushed descriptor dropped, a later eng_done ignored (completed unchanged).
- Length-0 descriptor between two normal ones → no engine command for it; issued and completed counters each +3.
